// File: rtl/ask4_pkg.sv
// Shared constants and level helpers for the 4-ASK transmit test source.
// Levels are signed 1s17; the outer level 3A is computed wide and clamped.
package ask4_pkg;

   localparam int LVL_W = 18;
   localparam int LFSR_W = 15;

   localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 15'h0001;

   // Gray-coded symbol alphabet, ordered from most negative to most positive level
   localparam logic [1:0] SYM_M3 = 2'b00;
   localparam logic [1:0] SYM_M1 = 2'b01;
   localparam logic [1:0] SYM_P1 = 2'b11;
   localparam logic [1:0] SYM_P3 = 2'b10;

   typedef logic signed [LVL_W-1:0] level_t;
   typedef logic signed [LVL_W+1:0] wide_t;

   localparam level_t LVL_MAX = 18'sd131071;
   localparam level_t LVL_MIN = -18'sd131072;
   localparam wide_t WIDE_MAX = 20'sd131071;
   localparam wide_t WIDE_MIN = -20'sd131072;

   function automatic level_t sat_level(input wide_t v);
      level_t r;
      if (v > WIDE_MAX) begin
         r = LVL_MAX;
      end else if (v < WIDE_MIN) begin
         r = LVL_MIN;
      end else begin
         r = level_t'(v[LVL_W-1:0]);
      end
      return r;
   endfunction

   // Negated terms are also clamped: -A and -3A can exceed +131071 for negative A
   function automatic level_t map_level(input logic [1:0] sym, input level_t a);
      wide_t a_w;
      wide_t a3_w;
      level_t r;
      a_w  = {{2{a[LVL_W-1]}}, a};
      a3_w = (a_w <<< 1) + a_w;
      case (sym)
         SYM_M3:  r = sat_level(-a3_w);
         SYM_M1:  r = sat_level(-a_w);
         SYM_P3:  r = sat_level(a3_w);
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/prbs15_2step.sv
// PRBS15 (x^15+x^14+1) Fibonacci LFSR advanced two steps per strobe.
// Reloads the seed from the all-zero lock-up state and flags the period wrap.
module prbs15_2step
   import ask4_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       step_en,
   output logic [1:0] sym_next,
   output logic       wrap
);

   logic [LFSR_W-1:0] state;
   logic [LFSR_W-1:0] nxt;

   function automatic logic [LFSR_W-1:0] step1(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[LFSR_W-1] ^ s[LFSR_W-2]};
   endfunction

   always_comb begin
      nxt = step1(step1(state));
      if (state == '0) begin
         nxt = SEED;
      end
   end

   assign sym_next = nxt[1:0];

   // wrap is a registered one-clk pulse following the strobe that returns to the seed
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SEED;
         wrap  <= 1'b0;
      end else begin
         wrap <= step_en && (nxt == SEED);
         if (step_en) begin
            state <= nxt;
         end
      end
   end

endmodule

// File: rtl/ask4_tx_symbol_gen.sv
// 4-ASK transmit test source: PRBS symbols, Gray-mapped sample-rate levels,
// delayed reference symbols for the receiver compare and a PRBS-wrap pulse.
module ask4_tx_symbol_gen
   import ask4_pkg::*;
#(
   parameter int                SYM_DELAY  = 2,
   parameter bit                ZERO_STUFF = 1'b1,
   parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_SEED_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    sym_clk_en,
   input  logic                    smp_clk_en,
   input  logic signed [LVL_W-1:0] ref_level,
   output logic        [1:0]       sym_out,
   output logic signed [LVL_W-1:0] map_out,
   output logic        [1:0]       sym_ref,
   output logic                    clear_accum
);

   logic [1:0] sym_next;
   logic       pend;
   logic [1:0] dly [SYM_DELAY];

   prbs15_2step #(
      .SEED(LFSR_SEED)
   ) u_prbs (
      .clk      (clk),
      .reset    (reset),
      .step_en  (sym_clk_en),
      .sym_next (sym_next),
      .wrap     (clear_accum)
   );

   // pend marks a symbol not yet placed on a sample; a coincident sample consumes it at once
   always_ff @(posedge clk) begin
      if (reset) begin
         sym_out <= '0;
         map_out <= '0;
         pend    <= 1'b0;
      end else begin
         if (sym_clk_en) begin
            sym_out <= sym_next;
         end
         if (sym_clk_en && smp_clk_en) begin
            map_out <= map_level(sym_next, ref_level);
            pend    <= 1'b0;
         end else if (smp_clk_en) begin
            if (pend) begin
               map_out <= map_level(sym_out, ref_level);
               pend    <= 1'b0;
            end else if (ZERO_STUFF) begin
               map_out <= '0;
            end
         end else if (sym_clk_en) begin
            pend <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYM_DELAY; i++) begin
            dly[i] <= '0;
         end
      end else if (sym_clk_en) begin
         dly[0] <= sym_out;
         for (int i = 1; i < SYM_DELAY; i++) begin
            dly[i] <= dly[i-1];
         end
      end
   end

   assign sym_ref = dly[SYM_DELAY-1];

endmodule

// File: tb/tb_ask4_tx_symbol_gen.sv
// Directed bench for ask4_tx_symbol_gen: cycle model feeds a scoreboard queue,
// plus constant-table checks of the PRBS start sequence and mapped levels.
module tb_ask4_tx_symbol_gen;
   import ask4_pkg::*;

   localparam logic [14:0] SEED = 15'h0001;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               sym_clk_en = 1'b0;
   logic               smp_clk_en = 1'b0;
   logic signed [17:0] ref_level = 18'sd16384;
   logic [1:0]         sym_out, sym_ref, sym_out_h, sym_ref_h;
   logic signed [17:0] map_out, map_out_h;
   logic               clear_accum, clear_accum_h;

   always #5 clk = ~clk;

   ask4_tx_symbol_gen #(.SYM_DELAY(2), .ZERO_STUFF(1'b1), .LFSR_SEED(SEED)) dut (
      .clk(clk), .reset(reset), .sym_clk_en(sym_clk_en), .smp_clk_en(smp_clk_en),
      .ref_level(ref_level), .sym_out(sym_out), .map_out(map_out),
      .sym_ref(sym_ref), .clear_accum(clear_accum));

   ask4_tx_symbol_gen #(.SYM_DELAY(2), .ZERO_STUFF(1'b0), .LFSR_SEED(SEED)) dut_h (
      .clk(clk), .reset(reset), .sym_clk_en(sym_clk_en), .smp_clk_en(smp_clk_en),
      .ref_level(ref_level), .sym_out(sym_out_h), .map_out(map_out_h),
      .sym_ref(sym_ref_h), .clear_accum(clear_accum_h));

   typedef struct {
      int sym;
      int sref;
      int mz;
      int mh;
      int clr;
   } exp_t;

   exp_t sb[$];
   int vectors = 0;
   int miscompares = 0;

   logic [14:0] m_lfsr;
   logic [1:0]  m_sym;
   logic [1:0]  m_dl [2];
   int          m_mz, m_mh, m_clr;
   logic        m_pend;

   logic [1:0] t1 [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};

   function automatic logic [14:0] m_step1(input logic [14:0] s);
      return {s[13:0], s[14] ^ s[13]};
   endfunction

   function automatic int clamp(input int v);
      if (v > 131071) return 131071;
      if (v < -131072) return -131072;
      return v;
   endfunction

   function automatic int m_level(input logic [1:0] s, input int a);
      case (s)
         2'b00:   return clamp(-3 * a);
         2'b01:   return clamp(-a);
         2'b11:   return a;
         default: return clamp(3 * a);
      endcase
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic s, input logic p);
      exp_t e;
      logic [14:0] nxt;
      int lv;
      reset = r;
      sym_clk_en = s;
      smp_clk_en = p;
      if (r) begin
         m_lfsr = SEED; m_sym = 2'b00; m_dl[0] = 2'b00; m_dl[1] = 2'b00;
         m_mz = 0; m_mh = 0; m_pend = 1'b0; m_clr = 0;
      end else begin
         nxt = (m_lfsr == 15'h0) ? SEED : m_step1(m_step1(m_lfsr));
         m_clr = (s && nxt == SEED) ? 1 : 0;
         if (s && p) begin
            lv = m_level(nxt[1:0], int'(ref_level));
            m_mz = lv; m_mh = lv; m_pend = 1'b0;
         end else if (p) begin
            if (m_pend) begin
               lv = m_level(m_sym, int'(ref_level));
               m_mz = lv; m_mh = lv; m_pend = 1'b0;
            end else begin
               m_mz = 0;
            end
         end else if (s) begin
            m_pend = 1'b1;
         end
         if (s) begin
            m_dl[1] = m_dl[0];
            m_dl[0] = m_sym;
            m_sym = nxt[1:0];
            m_lfsr = nxt;
         end
      end
      e.sym = int'(m_sym); e.sref = int'(m_dl[1]); e.mz = m_mz; e.mh = m_mh; e.clr = m_clr;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("sym_out", int'(sym_out), e.sym);
      chk("sym_ref", int'(sym_ref), e.sref);
      chk("map_out_zs", int'(map_out), e.mz);
      chk("map_out_hold", int'(map_out_h), e.mh);
      chk("clear_accum", int'(clear_accum), e.clr);
   endtask

   initial begin
      int pulses;
      int pulse_idx;
      int lvl;

      // 1: reset, then the known PRBS start sequence
      step(1, 0, 0);
      step(1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 1);
         chk("t1_sym", int'(sym_out), int'(t1[i]));
      end

      // 2: Gray mapping at A=16384 and saturating A=65535
      ref_level = 18'sd16384;
      for (int i = 0; i < 24; i++) begin
         step(0, 1, 1);
         case (m_sym)
            2'b00:   chk("lvl16k_m3", int'(map_out), -49152);
            2'b01:   chk("lvl16k_m1", int'(map_out), -16384);
            2'b11:   chk("lvl16k_p1", int'(map_out), 16384);
            default: chk("lvl16k_p3", int'(map_out), 49152);
         endcase
      end
      ref_level = 18'sd65535;
      for (int i = 0; i < 24; i++) begin
         step(0, 1, 1);
         case (m_sym)
            2'b00:   chk("lvl64k_m3", int'(map_out), -131072);
            2'b01:   chk("lvl64k_m1", int'(map_out), -65535);
            2'b11:   chk("lvl64k_p1", int'(map_out), 65535);
            default: chk("lvl64k_p3", int'(map_out), 131071);
         endcase
      end
      ref_level = -18'sd131072;
      for (int i = 0; i < 12; i++) step(0, 1, 1);

      // 3: sym every 4 clks, smp every clk; zero-stuff vs hold
      ref_level = 18'sd16384;
      for (int k = 0; k < 6; k++) begin
         step(0, 1, 1);
         lvl = m_level(m_sym, 16384);
         for (int j = 0; j < 3; j++) begin
            step(0, 0, 1);
            chk("zs_zero", int'(map_out), 0);
            chk("hold_level", int'(map_out_h), lvl);
         end
      end
      // pending symbol consumed by a later sample, idle hold, dropped symbol
      step(0, 1, 0);
      step(0, 0, 0);
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 1, 0);
      step(0, 1, 0);
      step(0, 0, 1);
      step(0, 0, 0);

      // 5: one full PRBS period from reset
      step(1, 0, 0);
      pulses = 0;
      pulse_idx = -1;
      for (int i = 0; i < 32767; i++) begin
         step(0, 1, 1);
         if (clear_accum === 1'b1) begin
            pulses++;
            pulse_idx = i;
         end
      end
      chk("wrap_pulse_count", pulses, 1);
      chk("wrap_pulse_index", pulse_idx, 32766);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 1);
         chk("repeat_sym", int'(sym_out), int'(t1[i]));
      end

      // lock-up recovery: an all-zero state reloads the seed on the next symbol
      force dut.u_prbs.state = 15'h0;
      force dut_h.u_prbs.state = 15'h0;
      m_lfsr = 15'h0;
      step(0, 1, 1);
      chk("lockup_sym", int'(sym_out), 1);
      release dut.u_prbs.state;
      release dut_h.u_prbs.state;
      step(1, 0, 0);

      // 6: reset mid-stream with both strobes high, then restart
      for (int i = 0; i < 5; i++) step(0, 1, 1);
      step(0, 1, 0);
      step(1, 1, 1);
      chk("rst_sym_out", int'(sym_out), 0);
      chk("rst_map_out", int'(map_out), 0);
      step(0, 0, 1);
      chk("rst_no_partial", int'(map_out_h), 0);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 1);
         chk("restart_sym", int'(sym_out), int'(t1[i]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
